// File: rtl/bus_if.sv
// bus_if: pipeline-to-SoC bus master (req/grant/strobe/ready); define BUS_IF_TIMEOUT_EN to abort ACCESS after TIMEOUT unready cycles
module bus_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              as_n,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    output logic              bus_req_n,
    input  logic              bus_grnt_n,
    output logic              bus_as_n,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_n
);
    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;
    state_t            state;
    logic [DATA_W-1:0] rd_buf;
    logic              tmo;
    logic              start;
    logic              rd_hit;
`ifdef BUS_IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    // tmo marks the last allowed ACCESS cycle, so busy drops in the abort cycle itself
    assign tmo = state == ACCESS && bus_rdy_n && cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (state == REQ)
            cnt <= '0;
        else if (state == ACCESS && bus_rdy_n)
            cnt <= cnt + CW'(1);
    end
`else
    assign tmo = 1'b0;
`endif
    assign start   = state == IDLE && !as_n && !flush;
    assign rd_hit  = state == ACCESS && !bus_rdy_n && bus_rw;
    assign busy    = start || state == REQ || (state == ACCESS && bus_rdy_n && !tmo);
    assign rd_data = rd_hit ? bus_rd_data : rd_buf;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            bus_req_n   <= 1'b1;
            bus_as_n    <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_buf      <= '0;
            err         <= 1'b0;
        end else begin
            err <= tmo;
            case (state)
                IDLE:
                    if (start) begin
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        bus_req_n   <= 1'b0;
                        state       <= REQ;
                    end
                REQ:
                    if (!bus_grnt_n) begin
                        bus_as_n <= 1'b0;
                        state    <= ACCESS;
                    end
                ACCESS: begin
                    bus_as_n <= 1'b1;
                    if (!bus_rdy_n || tmo) begin
                        rd_buf    <= tmo ? '0 : (bus_rw ? bus_rd_data : rd_buf);
                        bus_req_n <= 1'b1;
                        state     <= stall ? STALL : IDLE;
                    end
                end
                default:
                    state <= stall ? STALL : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_if.sv
// tb_bus_if: directed read/write/stall/flush/reset/timeout sequence with immediate-assertion checks
module tb_bus_if;
    logic        clk = 1'b0;
    logic        reset, stall, flush, as_n, rw;
    logic [29:0] addr;
    logic [31:0] wr_data, rd_data, bus_wr_data, bus_rd_data;
    logic        busy, err, bus_req_n, bus_grnt_n, bus_as_n, bus_rw, bus_rdy_n;
    logic [29:0] bus_addr;
    int          total = 0;
    int          bad = 0;

    bus_if dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .as_n(as_n), .rw(rw),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .err(err),
        .bus_req_n(bus_req_n), .bus_grnt_n(bus_grnt_n), .bus_as_n(bus_as_n), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_n(bus_rdy_n)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; as_n = 1'b1; rw = 1'b1;
        addr = '0; wr_data = '0; bus_grnt_n = 1'b1; bus_rdy_n = 1'b1; bus_rd_data = '0;
        nxt(); nxt(); #2;
        chk1("rst_req_n", bus_req_n, 1'b1);
        chk1("rst_as_n", bus_as_n, 1'b1);
        chk1("rst_rw", bus_rw, 1'b1);
        chkw("rst_addr", 32'(bus_addr), 32'h0);
        chkw("rst_wdata", bus_wr_data, 32'h0);
        chkw("rst_rdata", rd_data, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        reset = 1'b1;
        nxt();
        // minimum-latency read
        as_n = 1'b0; rw = 1'b1; addr = 30'd6; bus_grnt_n = 1'b0; #2;
        chk1("rd_c0_busy", busy, 1'b1);
        chk1("rd_c0_req_n", bus_req_n, 1'b1);
        nxt();
        as_n = 1'b1; #2;
        chk1("rd_c1_busy", busy, 1'b1);
        chk1("rd_c1_req_n", bus_req_n, 1'b0);
        chk1("rd_c1_as_n", bus_as_n, 1'b1);
        chkw("rd_c1_addr", 32'(bus_addr), 32'd6);
        chk1("rd_c1_rw", bus_rw, 1'b1);
        nxt();
        #2;
        chk1("rd_c2_as_n", bus_as_n, 1'b0);
        chk1("rd_c2_busy", busy, 1'b1);
        nxt();
        bus_rdy_n = 1'b0; bus_rd_data = 32'h1234_5678; #2;
        chk1("rd_c3_as_n", bus_as_n, 1'b1);
        chk1("rd_c3_busy", busy, 1'b0);
        chk1("rd_c3_req_n", bus_req_n, 1'b0);
        chkw("rd_c3_rdata", rd_data, 32'h1234_5678);
        nxt();
        bus_rdy_n = 1'b1; bus_rd_data = 32'hFFFF_FFFF; bus_grnt_n = 1'b1; #2;
        chkw("rd_c4_held", rd_data, 32'h1234_5678);
        chk1("rd_c4_req_n", bus_req_n, 1'b1);
        chk1("rd_c4_busy", busy, 1'b0);
        nxt();
        // write with three extra grant-wait cycles
        as_n = 1'b0; rw = 1'b0; addr = 30'h10; wr_data = 32'hDEAD_BEEF; #2;
        chk1("wr_c0_busy", busy, 1'b1);
        nxt();
        as_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus_grnt_n = (i == 4) ? 1'b0 : 1'b1; #2;
            chk1("wr_req_busy", busy, 1'b1);
            chk1("wr_req_req_n", bus_req_n, 1'b0);
            chk1("wr_req_as_n", bus_as_n, 1'b1);
            nxt();
        end
        bus_grnt_n = 1'b1; #2;
        chk1("wr_acc_as_n", bus_as_n, 1'b0);
        chk1("wr_acc_busy", busy, 1'b1);
        chk1("wr_acc_rw", bus_rw, 1'b0);
        chkw("wr_acc_addr", 32'(bus_addr), 32'h10);
        chkw("wr_acc_wdata", bus_wr_data, 32'hDEAD_BEEF);
        nxt();
        bus_rdy_n = 1'b0; bus_rd_data = 32'hAAAA_5555; #2;
        chk1("wr_done_busy", busy, 1'b0);
        chk1("wr_done_req_n", bus_req_n, 1'b0);
        chkw("wr_done_rdata", rd_data, 32'h1234_5678);
        nxt();
        bus_rdy_n = 1'b1; #2;
        chkw("wr_after_rdata", rd_data, 32'h1234_5678);
        chk1("wr_after_req_n", bus_req_n, 1'b1);
        nxt();
        // stall held across completion, then immediate new request
        as_n = 1'b0; rw = 1'b1; addr = 30'd7; bus_grnt_n = 1'b0; #2;
        chk1("st_c0_busy", busy, 1'b1);
        nxt();
        as_n = 1'b1; nxt();
        #2;
        chk1("st_c2_as_n", bus_as_n, 1'b0);
        nxt();
        bus_rdy_n = 1'b0; bus_rd_data = 32'hCAFE_0001; stall = 1'b1; #2;
        chk1("st_c3_busy", busy, 1'b0);
        chkw("st_c3_rdata", rd_data, 32'hCAFE_0001);
        nxt();
        bus_rdy_n = 1'b1; bus_grnt_n = 1'b1; as_n = 1'b0; addr = 30'h3FF;
        for (int i = 0; i < 4; i++) begin
            stall = (i < 3); #2;
            chk1("st_busy", busy, 1'b0);
            chk1("st_req_n", bus_req_n, 1'b1);
            chkw("st_addr", 32'(bus_addr), 32'd7);
            chkw("st_rdata", rd_data, 32'hCAFE_0001);
            nxt();
        end
        stall = 1'b0; addr = 30'd8; bus_grnt_n = 1'b0; #2;
        chk1("st_new_busy", busy, 1'b1);
        nxt();
        as_n = 1'b1; #2;
        chkw("st_new_addr", 32'(bus_addr), 32'd8);
        chk1("st_new_req_n", bus_req_n, 1'b0);
        nxt();
        nxt();
        bus_rdy_n = 1'b0; bus_rd_data = 32'h0BAD_F00D; #2;
        chkw("st_new_rdata", rd_data, 32'h0BAD_F00D);
        nxt();
        bus_rdy_n = 1'b1; bus_grnt_n = 1'b1; #2;
        chkw("st_new_held", rd_data, 32'h0BAD_F00D);
        chk1("st_new_req_n_rel", bus_req_n, 1'b1);
        nxt();
        // flush in IDLE blocks a request; flush during a transaction is ignored
        as_n = 1'b0; flush = 1'b1; addr = 30'd9; #2;
        chk1("fl_idle_busy", busy, 1'b0);
        nxt();
        as_n = 1'b1; flush = 1'b0; #2;
        chk1("fl_idle_req_n", bus_req_n, 1'b1);
        chk1("fl_idle_busy2", busy, 1'b0);
        nxt();
        as_n = 1'b0; bus_grnt_n = 1'b0; #2;
        chk1("fl_c0_busy", busy, 1'b1);
        nxt();
        flush = 1'b1; #2;
        chk1("fl_req_busy", busy, 1'b1);
        chk1("fl_req_req_n", bus_req_n, 1'b0);
        nxt();
        #2;
        chk1("fl_acc_as_n", bus_as_n, 1'b0);
        chk1("fl_acc_busy", busy, 1'b1);
        nxt();
        bus_rdy_n = 1'b0; bus_rd_data = 32'h55AA_55AA; #2;
        chk1("fl_done_busy", busy, 1'b0);
        chkw("fl_done_rdata", rd_data, 32'h55AA_55AA);
        nxt();
        bus_rdy_n = 1'b1; bus_grnt_n = 1'b1; as_n = 1'b1; flush = 1'b0; #2;
        chkw("fl_after_rdata", rd_data, 32'h55AA_55AA);
        chk1("fl_after_req_n", bus_req_n, 1'b1);
        nxt();
        // reset in the second ACCESS cycle
        as_n = 1'b0; rw = 1'b1; addr = 30'h21; bus_grnt_n = 1'b0; nxt();
        as_n = 1'b1; nxt();
        #2;
        chk1("rs_acc1_as_n", bus_as_n, 1'b0);
        nxt();
        reset = 1'b0; #2;
        chk1("rs_acc2_busy", busy, 1'b1);
        nxt();
        reset = 1'b1; bus_grnt_n = 1'b1; #2;
        chk1("rs_req_n", bus_req_n, 1'b1);
        chk1("rs_as_n", bus_as_n, 1'b1);
        chkw("rs_rdata", rd_data, 32'h0);
        chk1("rs_busy", busy, 1'b0);
        chk1("rs_err", err, 1'b0);
        chkw("rs_addr", 32'(bus_addr), 32'h0);
        nxt();
        as_n = 1'b0; addr = 30'h22; bus_grnt_n = 1'b0; #2;
        chk1("rs_idle_busy", busy, 1'b1);
        nxt();
        as_n = 1'b1; nxt();
        nxt();
        bus_rdy_n = 1'b0; bus_rd_data = 32'h0000_0077; #2;
        chkw("rs_new_rdata", rd_data, 32'h0000_0077);
        nxt();
        bus_rdy_n = 1'b1; bus_grnt_n = 1'b1; #2;
        chkw("rs_new_held", rd_data, 32'h0000_0077);
        nxt();
        // slave never ready
        as_n = 1'b0; addr = 30'h23; bus_grnt_n = 1'b0; nxt();
        as_n = 1'b1; nxt();
        bus_grnt_n = 1'b1;
`ifdef BUS_IF_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            #2;
            chk1("to_busy", busy, i < 16);
            chk1("to_err_low", err, 1'b0);
            nxt();
        end
        #2;
        chk1("to_err_pulse", err, 1'b1);
        chkw("to_rdata", rd_data, 32'h0);
        chk1("to_req_n", bus_req_n, 1'b1);
        chk1("to_busy_after", busy, 1'b0);
        nxt();
        #2;
        chk1("to_err_once", err, 1'b0);
`else
        for (int i = 1; i <= 20; i++) begin
            #2;
            chk1("nt_busy", busy, 1'b1);
            chk1("nt_err", err, 1'b0);
            chk1("nt_req_n", bus_req_n, 1'b0);
            nxt();
        end
        bus_rdy_n = 1'b0; bus_rd_data = 32'h0000_0099; #2;
        chkw("nt_late_rdata", rd_data, 32'h0000_0099);
        chk1("nt_late_busy", busy, 1'b0);
        nxt();
        bus_rdy_n = 1'b1; #2;
        chk1("nt_late_err", err, 1'b0);
        chkw("nt_late_held", rd_data, 32'h0000_0099);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
